// File: rtl/ex_exb2_if.sv
// EX1->EX2 lane bundle, late-result port and EX2 writeback/stall outputs.
// master = pipeline/EX1 side, slave = ex_exb2_stage.
interface ex_exb2_if;
   logic        exHoldIn;
   logic        opBraFlush;
   logic [5:0]  regIdRn1;
   logic [63:0] regValRn1;
   logic [5:0]  heldIdRn1;
   logic        lateValid;
   logic [63:0] regValLate;
   logic [5:0]  regIdRn2;
   logic [63:0] regValRn2;
   logic [5:0]  heldIdRn2;
   logic        exHold;
   logic        errTimeout;

   modport master (
      output exHoldIn, opBraFlush,
      output regIdRn1, regValRn1, heldIdRn1,
      output lateValid, regValLate,
      input  regIdRn2, regValRn2, heldIdRn2,
      input  exHold, errTimeout
   );

   modport slave (
      input  exHoldIn, opBraFlush,
      input  regIdRn1, regValRn1, heldIdRn1,
      input  lateValid, regValLate,
      output regIdRn2, regValRn2, heldIdRn2,
      output exHold, errTimeout
   );
endinterface

// File: rtl/ex_exb2_stage.sv
// EX2 stage, lanes 2+: registers Rn1 results and resolves held (late) results.
// Optional watchdog: define JX2_EXB2_WATCHDOG_EN. ZZR (no register) = 6'h3F.
module ex_exb2_stage
`ifdef JX2_EXB2_WATCHDOG_EN
#(
   parameter int unsigned MAX_WAIT = 16,
   parameter int unsigned CNT_W    = 5
)
`endif
(
   input logic      clock,
   input logic      reset,
   ex_exb2_if.slave bus
);

   localparam logic [5:0] ZZR = 6'h3F;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RSLV = 2'd2
   } st_t;

   st_t         sSt, nSt;
   logic [5:0]  sId, nId;
   logic [5:0]  sHeld, nHeld;
   logic [63:0] sVal, nVal;
   logic        advance;
   logic        late_hit;
   logic        late_miss;

`ifdef JX2_EXB2_WATCHDOG_EN
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT - 1);
   logic [CNT_W-1:0] sCnt, nCnt;
   logic             sErr, nErr;
   assign bus.errTimeout = sErr;
`else
   assign bus.errTimeout = 1'b0;
`endif

   always_comb begin
      bus.regIdRn2  = sId;
      bus.regValRn2 = sVal;
      bus.heldIdRn2 = ZZR;
      bus.exHold    = 1'b0;
      if (sSt == WAIT) begin
         if (bus.lateValid) begin
            bus.regIdRn2  = sHeld;
            bus.regValRn2 = bus.regValLate;
         end else begin
            bus.regIdRn2  = ZZR;
            bus.regValRn2 = '0;
            bus.heldIdRn2 = sHeld;
            bus.exHold    = 1'b1;
         end
      end
   end

   assign advance   = !bus.exHoldIn && !bus.exHold;
   assign late_hit  = !advance && (sSt == WAIT) && bus.lateValid;
   assign late_miss = (sSt == WAIT) && !bus.lateValid;

   always_comb begin
      nSt   = sSt;
      nId   = sId;
      nVal  = sVal;
      nHeld = sHeld;
`ifdef JX2_EXB2_WATCHDOG_EN
      nCnt  = sCnt;
      nErr  = sErr;
`endif
      unique case (1'b1)
         advance: begin
            nId   = bus.regIdRn1;
            nVal  = bus.regValRn1;
            nHeld = bus.heldIdRn1;
            nSt   = (bus.heldIdRn1 != ZZR) ? WAIT : IDLE;
`ifdef JX2_EXB2_WATCHDOG_EN
            nCnt  = '0;
`endif
            if (bus.opBraFlush) begin
               nId   = ZZR;
               nVal  = '0;
               nHeld = ZZR;
               nSt   = IDLE;
            end
         end
         // Stalled by others: park the late result so it is written once.
         late_hit: begin
            nId   = sHeld;
            nVal  = bus.regValLate;
            nHeld = ZZR;
            nSt   = RSLV;
         end
         late_miss: begin
`ifdef JX2_EXB2_WATCHDOG_EN
            if (sCnt == LIMIT) begin
               nErr  = 1'b1;
               nId   = sHeld;
               nVal  = '0;
               nHeld = ZZR;
               nSt   = RSLV;
            end else begin
               nCnt  = sCnt + 1'b1;
            end
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sSt   <= IDLE;
         sId   <= ZZR;
         sVal  <= '0;
         sHeld <= ZZR;
`ifdef JX2_EXB2_WATCHDOG_EN
         sCnt  <= '0;
         sErr  <= 1'b0;
`endif
      end else begin
         sSt   <= nSt;
         sId   <= nId;
         sVal  <= nVal;
         sHeld <= nHeld;
`ifdef JX2_EXB2_WATCHDOG_EN
         sCnt  <= nCnt;
         sErr  <= nErr;
`endif
      end
   end

endmodule

// File: tb/tb_ex_exb2_stage.sv
// Directed bench for ex_exb2_stage; tuple = {regIdRn2,regValRn2,heldIdRn2,exHold}.
// Builds with or without JX2_EXB2_WATCHDOG_EN.
module tb_ex_exb2_stage;

   localparam logic [5:0] ZZR = 6'h3F;
   localparam logic [76:0] IDL = {ZZR, 64'h0, ZZR, 1'b0};

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;
   logic [76:0] got;

   ex_exb2_if bus();

   ex_exb2_stage dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   assign got = {bus.regIdRn2, bus.regValRn2,
                 bus.heldIdRn2, bus.exHold};

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_in();
      bus.exHoldIn   = 1'b0;
      bus.opBraFlush = 1'b0;
      bus.regIdRn1   = ZZR;
      bus.regValRn1  = '0;
      bus.heldIdRn1  = ZZR;
      bus.lateValid  = 1'b0;
      bus.regValLate = '0;
   endtask

   task automatic lane_in(input logic [5:0] id,
                          input logic [63:0] val,
                          input logic [5:0] held);
      bus.regIdRn1  = id;
      bus.regValRn1 = val;
      bus.heldIdRn1 = held;
   endtask

   task automatic test_reset();
      idle_in();
      reset = 1'b0;
      #12;
      checks++;
      if (got !== IDL) begin
         failures++;
         $display("FAIL reset_out got=%h exp=%h", got, IDL);
      end
      checks++;
      if (bus.errTimeout !== 1'b0) begin
         failures++;
         $display("FAIL reset_err got=%b exp=0", bus.errTimeout);
      end
      @(negedge clock);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_passthrough();
      lane_in(6'h05, 64'h1234, ZZR);
      tick();
      lane_in(6'h12, 64'hFFFF_0000_0000_0001, ZZR);
      #1;
      checks++;
      if (got !== {6'h05, 64'h1234, ZZR, 1'b0}) begin
         failures++;
         $display("FAIL pass_1 got=%h exp=%h", got,
                  {6'h05, 64'h1234, ZZR, 1'b0});
      end
      tick();
      idle_in();
      #1;
      checks++;
      if (got !== {6'h12, 64'hFFFF_0000_0000_0001, ZZR, 1'b0}) begin
         failures++;
         $display("FAIL pass_2 got=%h exp=%h", got,
                  {6'h12, 64'hFFFF_0000_0000_0001, ZZR, 1'b0});
      end
      tick();
      checks++;
      if (got !== IDL) begin
         failures++;
         $display("FAIL pass_bubble got=%h exp=%h", got, IDL);
      end
   endtask

   task automatic test_held_next();
      lane_in(6'h07, 64'hDEAD, 6'h07);
      tick();
      idle_in();
      bus.lateValid  = 1'b1;
      bus.regValLate = 64'hAA;
      #1;
      checks++;
      if (got !== {6'h07, 64'hAA, ZZR, 1'b0}) begin
         failures++;
         $display("FAIL held_next got=%h exp=%h", got,
                  {6'h07, 64'hAA, ZZR, 1'b0});
      end
      tick();
      idle_in();
      #1;
      checks++;
      if (got !== IDL) begin
         failures++;
         $display("FAIL held_once got=%h exp=%h", got, IDL);
      end
   endtask

   task automatic test_held_wait();
      lane_in(6'h07, 64'h0, 6'h07);
      tick();
      idle_in();
      lane_in(6'h0A, 64'h11, ZZR);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (got !== {ZZR, 64'h0, 6'h07, 1'b1}) begin
            failures++;
            $display("FAIL wait_stall%0d got=%h exp=%h", i, got,
                     {ZZR, 64'h0, 6'h07, 1'b1});
         end
         tick();
      end
      bus.lateValid  = 1'b1;
      bus.regValLate = 64'h99;
      #1;
      checks++;
      if (got !== {6'h07, 64'h99, ZZR, 1'b0}) begin
         failures++;
         $display("FAIL wait_late got=%h exp=%h", got,
                  {6'h07, 64'h99, ZZR, 1'b0});
      end
      tick();
      idle_in();
      #1;
      checks++;
      if (got !== {6'h0A, 64'h11, ZZR, 1'b0}) begin
         failures++;
         $display("FAIL wait_next got=%h exp=%h", got,
                  {6'h0A, 64'h11, ZZR, 1'b0});
      end
      tick();
   endtask

   task automatic test_hold_resolve();
      lane_in(6'h07, 64'h0, 6'h07);
      tick();
      idle_in();
      bus.exHoldIn   = 1'b1;
      bus.lateValid  = 1'b1;
      bus.regValLate = 64'h55;
      #1;
      checks++;
      if (got !== {6'h07, 64'h55, ZZR, 1'b0}) begin
         failures++;
         $display("FAIL rslv_hit got=%h exp=%h", got,
                  {6'h07, 64'h55, ZZR, 1'b0});
      end
      tick();
      bus.regValLate = 64'h66;
      #1;
      checks++;
      if (got !== {6'h07, 64'h55, ZZR, 1'b0}) begin
         failures++;
         $display("FAIL rslv_2nd got=%h exp=%h", got,
                  {6'h07, 64'h55, ZZR, 1'b0});
      end
      tick();
      bus.lateValid = 1'b0;
      tick();
      bus.exHoldIn = 1'b0;
      #1;
      checks++;
      if (got !== {6'h07, 64'h55, ZZR, 1'b0}) begin
         failures++;
         $display("FAIL rslv_keep got=%h exp=%h", got,
                  {6'h07, 64'h55, ZZR, 1'b0});
      end
      tick();
      bus.lateValid  = 1'b1;
      bus.regValLate = 64'h77;
      #1;
      checks++;
      if (got !== IDL) begin
         failures++;
         $display("FAIL rslv_leave got=%h exp=%h", got, IDL);
      end
      tick();
      idle_in();
      #1;
      checks++;
      if (got !== IDL) begin
         failures++;
         $display("FAIL rslv_ignore got=%h exp=%h", got, IDL);
      end
   endtask

   task automatic test_flush();
      lane_in(6'h0B, 64'h22, ZZR);
      tick();
      lane_in(6'h05, 64'h77, ZZR);
      bus.opBraFlush = 1'b1;
      #1;
      checks++;
      if (got !== {6'h0B, 64'h22, ZZR, 1'b0}) begin
         failures++;
         $display("FAIL flush_cur got=%h exp=%h", got,
                  {6'h0B, 64'h22, ZZR, 1'b0});
      end
      tick();
      lane_in(6'h07, 64'h0, 6'h07);
      #1;
      checks++;
      if (got !== IDL) begin
         failures++;
         $display("FAIL flush_kill got=%h exp=%h", got, IDL);
      end
      tick();
      idle_in();
      #1;
      checks++;
      if (got !== IDL) begin
         failures++;
         $display("FAIL flush_held got=%h exp=%h", got, IDL);
      end
      lane_in(6'h0C, 64'h33, ZZR);
      tick();
      lane_in(6'h05, 64'h44, ZZR);
      bus.exHoldIn   = 1'b1;
      bus.opBraFlush = 1'b1;
      tick();
      idle_in();
      #1;
      checks++;
      if (got !== {6'h0C, 64'h33, ZZR, 1'b0}) begin
         failures++;
         $display("FAIL flush_hold got=%h exp=%h", got,
                  {6'h0C, 64'h33, ZZR, 1'b0});
      end
      tick();
   endtask

   task automatic test_timeout();
      lane_in(6'h07, 64'h0, 6'h07);
      tick();
      idle_in();
`ifdef JX2_EXB2_WATCHDOG_EN
      for (int k = 0; k < 16; k++) begin
         #1;
         checks++;
         if (got !== {ZZR, 64'h0, 6'h07, 1'b1}) begin
            failures++;
            $display("FAIL wd_stall%0d got=%h exp=%h", k, got,
                     {ZZR, 64'h0, 6'h07, 1'b1});
         end
         tick();
      end
      #1;
      checks++;
      if ({got, bus.errTimeout} !== {6'h07, 64'h0, ZZR, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL wd_fire got=%h exp=%h", {got, bus.errTimeout},
                  {6'h07, 64'h0, ZZR, 1'b0, 1'b1});
      end
      tick();
      #1;
      checks++;
      if (bus.errTimeout !== 1'b1) begin
         failures++;
         $display("FAIL wd_sticky got=%b exp=1", bus.errTimeout);
      end
      lane_in(6'h07, 64'h0, 6'h07);
      tick();
      idle_in();
`else
      for (int k = 0; k < 20; k++) begin
         #1;
         checks++;
         if (got !== {ZZR, 64'h0, 6'h07, 1'b1}) begin
            failures++;
            $display("FAIL nowd_stall%0d got=%h exp=%h", k, got,
                     {ZZR, 64'h0, 6'h07, 1'b1});
         end
         tick();
      end
      checks++;
      if (bus.errTimeout !== 1'b0) begin
         failures++;
         $display("FAIL nowd_err got=%b exp=0", bus.errTimeout);
      end
`endif
      #1;
      checks++;
      if (got !== {ZZR, 64'h0, 6'h07, 1'b1}) begin
         failures++;
         $display("FAIL rst_pre got=%h exp=%h", got,
                  {ZZR, 64'h0, 6'h07, 1'b1});
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({got, bus.errTimeout} !== {IDL, 1'b0}) begin
         failures++;
         $display("FAIL rst_async got=%h exp=%h",
                  {got, bus.errTimeout}, {IDL, 1'b0});
      end
      #1;
      reset = 1'b1;
      tick();
      bus.lateValid  = 1'b1;
      bus.regValLate = 64'hBB;
      #1;
      checks++;
      if (got !== IDL) begin
         failures++;
         $display("FAIL rst_drop got=%h exp=%h", got, IDL);
      end
      tick();
      idle_in();
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_held_next();
      test_held_wait();
      test_hold_resolve();
      test_flush();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
